hdmi_timing_gen: RTL and testbench

Video timing generator and pixel-stream aligner on the `clk_pix` domain, downstream of the HDMI clock/reset stage and upstream of the TMDS encoder/serializer. It generates CEA-861 raster timing (default 1280x720p60). It pulls pixels from the upstream ready/valid stream during the active region and emits registered RGB with aligned DE/HSYNC/VSYNC. A lock FSM aligns the stream's start-of-frame marker to raster origin (0,0).

---
 rtl/hdmi_pkg.sv | 38 +++
 rtl/hdmi_raster_ctr.sv | 57 +++++
 rtl/hdmi_timing_gen.sv | 136 +++++++++++++
 tb/tb_hdmi_timing_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared video types: raster timing record, pixel type, lock state.
// Timing constants for the supported CEA-861 modes.
package hdmi_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } video_timing_t;

  localparam video_timing_t TIMING_720P60 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
  };

  localparam video_timing_t TIMING_1080P30 = '{
    h_active: 1920, h_fp: 88, h_sync: 44, h_bp: 148,
    v_active: 1080, v_fp: 4,  v_sync: 5,  v_bp: 36
  };

  typedef logic [23:0] rgb_t;

  typedef enum logic {SEEK = 1'b0, LOCKED = 1'b1} lock_state_t;

  function automatic int h_total(video_timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int v_total(video_timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/hdmi_raster_ctr.sv
// Free-running h/v raster counters with region decode (active, raw sync, origin).
// Decode outputs are combinational from the current counter state.
module hdmi_raster_ctr
  import hdmi_pkg::*;
#(
  parameter video_timing_t T = TIMING_720P60
) (
  input  logic clk_pix,
  input  logic srst,
  output logic active,
  output logic hs,
  output logic vs,
  output logic origin
);

  localparam int HT = h_total(T);
  localparam int VT = v_total(T);
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(T.h_active);
  localparam logic [HW-1:0] HS_FIRST = HW'(T.h_active + T.h_fp);
  localparam logic [HW-1:0] HS_LAST  = HW'(T.h_active + T.h_fp + T.h_sync - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(T.v_active);
  localparam logic [VW-1:0] VS_FIRST = VW'(T.v_active + T.v_fp);
  localparam logic [VW-1:0] VS_LAST  = VW'(T.v_active + T.v_fp + T.v_sync - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    // line and frame wrap land on the same edge, no idle cycle between frames
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
    active = (h_q < H_ACT) && (v_q < V_ACT);
    hs     = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    vs     = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    origin = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk_pix) begin
    if (srst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator that pulls pixels in the active region and aligns the stream SOF to (0,0).
// All vid_* outputs lag the raster counters by one cycle; s_ready is combinational.
module hdmi_timing_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk_pix,
  input  logic        srst,
  input  logic [23:0] s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  output logic [23:0] vid_rgb,
  output logic        vid_de,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_fs,
  output logic        locked,
  output logic        underflow,
  input  logic        underflow_clr,
  output logic        sof_err
);

  localparam video_timing_t TIM = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
  };

  logic active, hs, vs, origin;

  hdmi_raster_ctr #(.T(TIM)) u_raster (
    .clk_pix (clk_pix),
    .srst    (srst),
    .active  (active),
    .hs      (hs),
    .vs      (vs),
    .origin  (origin)
  );

  lock_state_t state_q, state_d;
  rgb_t        rgb_q, rgb_d, pix;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic        locked_q, locked_d, underflow_q, underflow_d, sof_err_q, sof_err_d;
  logic        starve;

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    pix       = '0;
    sof_err_d = 1'b0;
    starve    = 1'b0;
    case (state_q)
      SEEK: begin
        // hold an SOF pixel at the head until the raster reaches origin; drain anything else
        if (s_valid && s_sof) begin
          s_ready = origin;
          if (origin) begin
            state_d = LOCKED;
            pix     = s_data;
          end
        end else begin
          s_ready = 1'b1;
        end
      end
      LOCKED: begin
        if (active) begin
          s_ready = 1'b1;
          if (!s_valid) begin
            starve = 1'b1;
          end else if (s_sof != origin) begin
            // a misplaced SOF stays at the head so SEEK can realign on it
            sof_err_d = 1'b1;
            state_d   = SEEK;
            s_ready   = origin;
          end else begin
            pix = s_data;
          end
        end
      end
      default: state_d = SEEK;
    endcase
    if (srst) s_ready = 1'b0;

    rgb_d       = active ? pix : '0;
    de_d        = active;
    hs_d        = hs ? HS_POL : !HS_POL;
    vs_d        = vs ? VS_POL : !VS_POL;
    fs_d        = origin;
    locked_d    = (state_d == LOCKED);
    underflow_d = starve | (underflow_q & ~underflow_clr);
  end

  always_ff @(posedge clk_pix) begin
    if (srst) begin
      state_q     <= SEEK;
      rgb_q       <= '0;
      de_q        <= 1'b0;
      hs_q        <= !HS_POL;
      vs_q        <= !VS_POL;
      fs_q        <= 1'b0;
      locked_q    <= 1'b0;
      underflow_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
      locked_q    <= locked_d;
      underflow_q <= underflow_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign vid_rgb   = rgb_q;
  assign vid_de    = de_q;
  assign vid_hs    = hs_q;
  assign vid_vs    = vs_q;
  assign vid_fs    = fs_q;
  assign locked    = locked_q;
  assign underflow = underflow_q;
  assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a reduced raster (28x11) with a position-based reference model.
module tb_hdmi_timing_gen;

  localparam int HA = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;

  logic        clk_pix = 1'b0;
  logic        srst = 1'b1;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        s_ready;
  logic [23:0] vid_rgb;
  logic        vid_de, vid_hs, vid_vs, vid_fs, locked, underflow, sof_err;
  logic        underflow_clr = 1'b0;

  hdmi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HP), .VS_POL(VP)
  ) dut (
    .clk_pix(clk_pix), .srst(srst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .vid_rgb(vid_rgb), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_fs(vid_fs), .locked(locked), .underflow(underflow), .underflow_clr(underflow_clr),
    .sof_err(sof_err)
  );

  always #5 clk_pix = ~clk_pix;

  int errors = 0;
  int checks = 0;

  // reference model state: linear position in the frame, lock flag, sticky underflow
  int          m_pos = 0;
  bit          m_locked = 1'b0;
  bit          m_uf = 1'b0;
  logic [30:0] exp_vec;
  logic        exp_ready, obs_ready;
  bit          chk_ready;
  logic [23:0] src_data = 24'h1;
  bit          src_sof = 1'b0;
  logic [30:0] out_vec;
  localparam logic [30:0] RST_VEC = {1'b0, !HP, !VP, 4'b0000, 24'h0};

  assign out_vec = {vid_de, vid_hs, vid_vs, vid_fs, locked, underflow, sof_err, vid_rgb};

  function automatic int P(int h, int v);
    return v * HT + h;
  endfunction

  // One clock: present source head, predict, sample s_ready, advance past the edge.
  task automatic cycle();
    int h, v;
    bit act, org, hsa, vsa, acquire, starve, misplaced, missing, shown, new_locked, new_uf;
    logic [23:0] pix;
    s_data = src_data;
    s_sof  = src_sof;
    #1;
    h   = m_pos % HT;
    v   = m_pos / HT;
    act = (h < HA) && (v < VA);
    org = (m_pos == 0);
    hsa = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vsa = (v >= VA + VFP) && (v < VA + VFP + VSW);
    acquire   = !m_locked && org && s_valid && s_sof;
    starve    = m_locked && act && !s_valid;
    misplaced = m_locked && act && !org && s_valid && s_sof;
    missing   = m_locked && org && s_valid && !s_sof;
    exp_ready = m_locked ? (act && !misplaced) : (!(s_valid && s_sof) || org);
    shown     = acquire || (m_locked && act && s_valid && !misplaced && !missing);
    pix       = shown ? s_data : 24'h0;
    new_locked = acquire || (m_locked && !misplaced && !missing);
    new_uf     = starve || (m_uf && !underflow_clr);
    chk_ready = !srst;
    obs_ready = s_ready;
    if (srst) begin
      exp_vec  = RST_VEC;
      m_pos    = 0;
      m_locked = 1'b0;
      m_uf     = 1'b0;
    end else begin
      exp_vec  = {act, hsa ? HP : !HP, vsa ? VP : !VP, org, new_locked, new_uf,
                  misplaced || missing, pix};
      if (s_valid && exp_ready) begin
        src_data = src_data + 24'h1;
        src_sof  = 1'b0;
      end
      m_pos    = (m_pos + 1) % FRAME;
      m_locked = new_locked;
      m_uf     = new_uf;
    end
    @(posedge clk_pix);
    @(negedge clk_pix);
  endtask

  task automatic test_reset();
    srst = 1'b1;
    s_valid = 1'b0;
    repeat (10) begin
      cycle();
      checks++;
      if (out_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_hold: got %h expected %h", out_vec, exp_vec);
      end
    end
    srst = 1'b0;
    checks++;
    if (out_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_release_first_cycle: got %h expected %h", out_vec, RST_VEC);
    end
    cycle();
    checks++;
    if (vid_de !== 1'b1 || vid_fs !== 1'b1 || vid_rgb !== 24'h0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_de: got de=%b fs=%b rgb=%h rdy=%b expected de=1 fs=1 rgb=000000 rdy=1",
               vid_de, vid_fs, vid_rgb, obs_ready);
    end
  endtask

  task automatic test_raster();
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    int de_rise[$], hs_rise[$], fs_at[$];
    logic pde, phs;
    s_valid = 1'b0;
    for (int k = 0; k < FRAME && m_pos != 0; k++) begin
      cycle();
      checks++;
      if (out_vec !== exp_vec || (chk_ready && obs_ready !== exp_ready)) begin
        errors++;
        $display("FAIL raster_align pos=%0d: got %h rdy=%b expected %h rdy=%b", m_pos, out_vec, obs_ready, exp_vec, exp_ready);
      end
    end
    pde = vid_de;
    phs = (vid_hs == HP);
    for (int i = 0; i <= FRAME; i++) begin
      cycle();
      checks++;
      if (out_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL raster pos=%0d: got %h rdy=%b expected %h rdy=%b", m_pos, out_vec, obs_ready, exp_vec, exp_ready);
      end
      if (i < FRAME) begin
        if (vid_de) de_cnt++;
        if (vid_hs == HP) hs_cnt++;
        if (vid_vs == VP) vs_cnt++;
      end
      if (vid_fs) fs_at.push_back(i);
      if (vid_de && !pde) de_rise.push_back(i);
      if ((vid_hs == HP) && !phs) hs_rise.push_back(i);
      pde = vid_de;
      phs = (vid_hs == HP);
    end
    checks++;
    if (de_cnt != HA * VA || hs_cnt != HSW * VT || vs_cnt != VSW * HT) begin
      errors++;
      $display("FAIL raster_counts: got de=%0d hs=%0d vs=%0d expected de=%0d hs=%0d vs=%0d",
               de_cnt, hs_cnt, vs_cnt, HA * VA, HSW * VT, VSW * HT);
    end
    checks++;
    if (fs_at.size() != 2 || fs_at[0] != 0 || fs_at[1] != FRAME) begin
      errors++;
      $display("FAIL frame_period: got %0d pulses first=%0d expected 2 pulses at 0 and %0d",
               fs_at.size(), (fs_at.size() > 0) ? fs_at[0] : -1, FRAME);
    end
    checks++;
    if (de_rise.size() < 2 || hs_rise.size() < 1 || de_rise[1] - de_rise[0] != HT ||
        hs_rise[0] - de_rise[0] != HA + HFP) begin
      errors++;
      $display("FAIL line_period: got %0d de rises, hs %0d rises expected line %0d hs offset %0d",
               de_rise.size(), hs_rise.size(), HT, HA + HFP);
    end
  endtask

  task automatic test_lock();
    s_valid = 1'b0;
    for (int k = 0; k < 2 * FRAME && m_pos != P(10, 2); k++) cycle();
    src_data = 24'h1;
    src_sof  = 1'b1;
    s_valid  = 1'b1;
    for (int k = 0; k < 2 * FRAME && m_pos != 0; k++) begin
      cycle();
      checks++;
      if (out_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL lock_wait pos=%0d: got %h rdy=%b expected %h rdy=%b", m_pos, out_vec, obs_ready, exp_vec, exp_ready);
      end
    end
    cycle();
    checks++;
    if (vid_fs !== 1'b1 || vid_rgb !== 24'h1 || locked !== 1'b1 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL lock_origin: got fs=%b rgb=%h locked=%b rdy=%b expected fs=1 rgb=000001 locked=1 rdy=1",
               vid_fs, vid_rgb, locked, obs_ready);
    end
    for (int k = 0; k < 2 * FRAME && m_pos != P(0, 1); k++) begin
      cycle();
      checks++;
      if (out_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL lock_run pos=%0d: got %h rdy=%b expected %h rdy=%b", m_pos, out_vec, obs_ready, exp_vec, exp_ready);
      end
    end
  endtask

  task automatic test_underflow();
    int p;
    for (int k = 0; k < 2 * FRAME && m_pos != P(10, 2); k++) begin
      p = m_pos;
      s_valid = !((p >= P(5, 1) && p < P(8, 1)) || p == P(5, 2));
      underflow_clr = (p == P(20, 1)) || (p == P(5, 2));
      cycle();
      checks++;
      if (out_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL underflow_run pos=%0d: got %h rdy=%b expected %h rdy=%b", m_pos, out_vec, obs_ready, exp_vec, exp_ready);
      end
      if (p >= P(5, 1) && p < P(8, 1)) begin
        checks++;
        if (vid_rgb !== 24'h0 || vid_de !== 1'b1 || underflow !== 1'b1 || locked !== 1'b1) begin
          errors++;
          $display("FAIL underflow_black x=%0d: got rgb=%h de=%b uf=%b locked=%b expected rgb=000000 de=1 uf=1 locked=1",
                   p % HT, vid_rgb, vid_de, underflow, locked);
        end
      end
      if (p == P(12, 1)) begin
        checks++;
        if (underflow !== 1'b1 || locked !== 1'b1) begin
          errors++;
          $display("FAIL underflow_sticky: got uf=%b locked=%b expected uf=1 locked=1", underflow, locked);
        end
      end
      if (p == P(20, 1)) begin
        checks++;
        if (underflow !== 1'b0) begin
          errors++;
          $display("FAIL underflow_clr: got uf=%b expected uf=0", underflow);
        end
      end
      if (p == P(5, 2)) begin
        checks++;
        if (underflow !== 1'b1) begin
          errors++;
          $display("FAIL clr_vs_set: got uf=%b expected uf=1", underflow);
        end
      end
    end
    s_valid = 1'b1;
    underflow_clr = 1'b0;
  endtask

  task automatic test_misplaced_sof();
    logic [23:0] sof_pix;
    s_valid = 1'b1;
    for (int k = 0; k < 2 * FRAME && m_pos != P(5, 3); k++) cycle();
    src_sof = 1'b1;
    sof_pix = src_data;
    cycle();
    checks++;
    if (sof_err !== 1'b1 || locked !== 1'b0 || obs_ready !== 1'b0 || vid_rgb !== 24'h0) begin
      errors++;
      $display("FAIL misplaced_sof: got err=%b locked=%b rdy=%b rgb=%h expected err=1 locked=0 rdy=0 rgb=000000",
               sof_err, locked, obs_ready, vid_rgb);
    end
    for (int k = 0; k < 2 * FRAME && m_pos != 0; k++) begin
      cycle();
      checks++;
      if (out_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL seek_wait pos=%0d: got %h rdy=%b expected %h rdy=%b", m_pos, out_vec, obs_ready, exp_vec, exp_ready);
      end
    end
    cycle();
    checks++;
    if (locked !== 1'b1 || vid_rgb !== sof_pix || vid_fs !== 1'b1 || sof_err !== 1'b0) begin
      errors++;
      $display("FAIL relock: got locked=%b rgb=%h fs=%b err=%b expected locked=1 rgb=%h fs=1 err=0",
               locked, vid_rgb, vid_fs, sof_err, sof_pix);
    end
  endtask

  task automatic test_missing_sof();
    s_valid = 1'b1;
    for (int k = 0; k < 2 * FRAME && m_pos != 0; k++) begin
      cycle();
      checks++;
      if (out_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL missing_run pos=%0d: got %h rdy=%b expected %h rdy=%b", m_pos, out_vec, obs_ready, exp_vec, exp_ready);
      end
    end
    cycle();
    checks++;
    if (sof_err !== 1'b1 || locked !== 1'b0 || vid_rgb !== 24'h0) begin
      errors++;
      $display("FAIL missing_sof: got err=%b locked=%b rgb=%h expected err=1 locked=0 rgb=000000", sof_err, locked, vid_rgb);
    end
    cycle();
    checks++;
    if (obs_ready !== 1'b1 || vid_rgb !== 24'h0 || sof_err !== 1'b0) begin
      errors++;
      $display("FAIL seek_discard: got rdy=%b rgb=%h err=%b expected rdy=1 rgb=000000 err=0", obs_ready, vid_rgb, sof_err);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3 * FRAME; k++) begin
      s_valid = ($urandom_range(7) != 0);
      if (m_pos == FRAME - 2 || $urandom_range(63) == 0) src_sof = 1'b1;
      underflow_clr = ($urandom_range(15) == 0);
      cycle();
      checks++;
      if (out_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL random pos=%0d: got %h rdy=%b expected %h rdy=%b", m_pos, out_vec, obs_ready, exp_vec, exp_ready);
      end
    end
    underflow_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int fs_at[$];
    s_valid = 1'b0;
    for (int k = 0; k < 2 * FRAME && m_pos != P(3, 4); k++) cycle();
    srst = 1'b1;
    cycle();
    srst = 1'b0;
    checks++;
    if (out_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected %h", out_vec, RST_VEC);
    end
    for (int i = 0; i <= FRAME; i++) begin
      cycle();
      checks++;
      if (out_vec !== exp_vec || obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL reset_mid_run pos=%0d: got %h rdy=%b expected %h rdy=%b", m_pos, out_vec, obs_ready, exp_vec, exp_ready);
      end
      if (vid_fs) fs_at.push_back(i);
    end
    checks++;
    if (fs_at.size() != 2 || fs_at[0] != 0 || fs_at[1] != FRAME) begin
      errors++;
      $display("FAIL reset_mid_period: got %0d pulses first=%0d expected 2 pulses at 0 and %0d",
               fs_at.size(), (fs_at.size() > 0) ? fs_at[0] : -1, FRAME);
    end
  endtask

  initial begin
    @(negedge clk_pix);
    test_reset();
    test_raster();
    test_lock();
    test_underflow();
    test_misplaced_sof();
    test_missing_sof();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
